// File: rtl/aes_pkg.sv
// Shared types and constants for the byte-serial SubBytes engine.
// Operand sizes, byte-count width and grant encodings.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SUB,
        DONE
    } state_t;

    localparam int N_BLK = 16;
    localparam int N_WRD = 4;
    localparam int CNT_W = 4;

    localparam logic [CNT_W-1:0] CNT_BLK = CNT_W'(N_BLK - 1);
    localparam logic [CNT_W-1:0] CNT_WRD = CNT_W'(N_WRD - 1);

    localparam logic [1:0] GNT_BLK = 2'b01;
    localparam logic [1:0] GNT_WRD = 2'b10;

endpackage

// File: rtl/aes_sbox_byte.sv
// Combinational FIPS-197 forward S-box, one byte in, one byte out.
// Table form so it maps to a ROM/LUT and is reusable by other blocks.
module aes_sbox_byte (
    input  logic [7:0] a,
    output logic [7:0] s
);

    always_comb begin
        s = 8'h00;
        case (a)
            8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b;
            8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
            8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b;
            8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
            8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d;
            8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
            8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf;
            8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
            8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26;
            8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
            8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1;
            8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
            8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3;
            8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
            8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2;
            8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
            8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a;
            8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
            8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3;
            8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
            8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed;
            8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
            8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39;
            8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
            8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb;
            8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
            8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f;
            8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
            8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f;
            8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
            8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21;
            8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
            8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec;
            8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
            8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d;
            8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
            8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc;
            8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
            8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14;
            8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
            8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a;
            8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
            8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62;
            8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
            8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d;
            8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
            8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea;
            8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
            8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e;
            8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
            8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f;
            8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
            8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66;
            8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
            8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9;
            8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
            8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11;
            8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
            8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9;
            8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
            8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d;
            8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
            8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f;
            8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
        endcase
    end

endmodule

// File: rtl/subbytes_arbiter.sv
// Shared byte-serial SubBytes engine: round-robin between block SubBytes
// and key-schedule SubWord, one S-box lookup per clock.
module subbytes_arbiter
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         blk_req,
    input  logic [127:0] blk_in,
    input  logic         wrd_req,
    input  logic [31:0]  wrd_in,
    output logic         blk_done,
    output logic [127:0] blk_out,
    output logic         wrd_done,
    output logic [31:0]  wrd_out,
    output logic [1:0]   gnt,
    output logic         busy
);

    state_t             state;
    state_t             state_d;
    logic [1:0]         grant_d;
    logic [1:0]         last_gnt;
    logic [127:0]       opr;
    logic [127:0]       res;
    logic [127:0]       res_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [7:0]         sb_out;

    aes_sbox_byte u_sbox (
        .a (opr[7:0]),
        .s (sb_out)
    );

    assign res_nxt = {sb_out, res[127:8]};
    assign busy    = (state != IDLE);

    always_comb begin
        state_d = state;
        grant_d = 2'b00;
        case (state)
            IDLE: begin
                if (blk_req && wrd_req) begin
                    grant_d = (last_gnt == GNT_WRD) ? GNT_BLK : GNT_WRD;
                end else if (blk_req) begin
                    grant_d = GNT_BLK;
                end else if (wrd_req) begin
                    grant_d = GNT_WRD;
                end
                if (grant_d != 2'b00) begin
                    state_d = SUB;
                end
            end
            SUB: begin
                if (cnt == '0) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            gnt      <= 2'b00;
            last_gnt <= GNT_WRD;
            opr      <= '0;
            res      <= '0;
            cnt      <= '0;
            blk_done <= 1'b0;
            wrd_done <= 1'b0;
            blk_out  <= '0;
            wrd_out  <= '0;
        end else begin
            state    <= state_d;
            blk_done <= 1'b0;
            wrd_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_d != 2'b00) begin
                        gnt      <= grant_d;
                        last_gnt <= grant_d;
                        if (grant_d == GNT_BLK) begin
                            opr <= blk_in;
                            cnt <= CNT_BLK;
                        end else begin
                            opr <= {96'b0, wrd_in};
                            cnt <= CNT_WRD;
                        end
                    end
                end
                SUB: begin
                    res <= res_nxt;
                    opr <= opr >> 8;
                    // Results are registered on the last lookup so they
                    // are already valid while the FSM sits in DONE.
                    if (cnt == '0) begin
                        if (gnt == GNT_BLK) begin
                            blk_out  <= res_nxt;
                            blk_done <= 1'b1;
                        end else begin
                            wrd_out  <= res_nxt[127:96];
                            wrd_done <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: gnt <= 2'b00;
                default: gnt <= 2'b00;
            endcase
        end
    end

endmodule

// File: tb/tb_subbytes_arbiter.sv
// Randomized bench for subbytes_arbiter against a transaction-level model
// with an S-box computed from GF(2^8) inversion plus the affine map.
module tb_subbytes_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         blk_req;
    logic [127:0] blk_in;
    logic         wrd_req;
    logic [31:0]  wrd_in;
    logic         blk_done;
    logic [127:0] blk_out;
    logic         wrd_done;
    logic [31:0]  wrd_out;
    logic [1:0]   gnt;
    logic         busy;

    always #5 clk = ~clk;

    subbytes_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .blk_req  (blk_req),
        .blk_in   (blk_in),
        .wrd_req  (wrd_req),
        .wrd_in   (wrd_in),
        .blk_done (blk_done),
        .blk_out  (blk_out),
        .wrd_done (wrd_done),
        .wrd_out  (wrd_out),
        .gnt      (gnt),
        .busy     (busy)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int t = 0;

    logic [7:0] sb [256];

    bit           act;
    bit           side;
    bit           m_last;
    int           st;
    int           len;
    logic [127:0] m_res;
    logic [127:0] m_blk_out;
    logic [31:0]  m_wrd_out;

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s cycle=%0d got=%h want=%h", tag, t, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a,
                                        input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl1(input logic [7:0] x);
        return {x[6:0], x[7]};
    endfunction

    function automatic logic [7:0] sbox_math(input logic [7:0] v);
        logic [7:0] inv;
        logic [7:0] r;
        logic [7:0] acc;
        inv = 8'h00;
        for (int y = 1; y < 256; y++) begin
            if (v != 8'h00 && gmul(v, 8'(y)) == 8'h01) inv = 8'(y);
        end
        acc = inv;
        r = inv;
        for (int k = 0; k < 4; k++) begin
            r = rotl1(r);
            acc = acc ^ r;
        end
        return acc ^ 8'h63;
    endfunction

    function automatic logic [127:0] ref_block(input logic [127:0] op);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = sb[op[8*i +: 8]];
        return r;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] op);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = sb[op[8*i +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One clock cycle: check the cycle's outputs, act as both requesters,
    // then let the model arbitrate on the requests seen this cycle.
    task automatic tick(input bit want_b, input logic [127:0] ob,
                        input bit want_w, input logic [31:0] ow,
                        input bit do_rst);
        logic [1:0] e_gnt;
        bit         e_bd;
        bit         e_wd;
        e_gnt = 2'b00;
        e_bd  = 1'b0;
        e_wd  = 1'b0;
        if (act && t > st && t <= st + len + 1) e_gnt = side ? 2'b10 : 2'b01;
        if (act && t == st + len + 1) begin
            if (side) begin
                e_wd = 1'b1;
                m_wrd_out = m_res[31:0];
            end else begin
                e_bd = 1'b1;
                m_blk_out = m_res;
            end
        end
        check("gnt", 128'(gnt), 128'(e_gnt));
        check("busy", 128'(busy), 128'(e_gnt != 2'b00));
        check("blk_done", 128'(blk_done), 128'(e_bd));
        check("wrd_done", 128'(wrd_done), 128'(e_wd));
        check("blk_out", blk_out, m_blk_out);
        check("wrd_out", 128'(wrd_out), 128'(m_wrd_out));

        if (e_bd) blk_req = 1'b0;
        if (e_wd) wrd_req = 1'b0;
        if (do_rst) begin
            blk_req = 1'b0;
            wrd_req = 1'b0;
        end else begin
            if (want_b && !blk_req) begin
                blk_req = 1'b1;
                blk_in  = ob;
            end
            if (want_w && !wrd_req) begin
                wrd_req = 1'b1;
                wrd_in  = ow;
            end
        end
        rst = !do_rst;

        if (do_rst) begin
            act       = 1'b0;
            m_last    = 1'b1;
            m_blk_out = '0;
            m_wrd_out = '0;
        end else begin
            if (act && t >= st + len + 2) act = 1'b0;
            if (!act && (blk_req || wrd_req)) begin
                if (blk_req && wrd_req) side = !m_last;
                else side = wrd_req;
                act    = 1'b1;
                st     = t;
                len    = side ? 4 : 16;
                m_res  = side ? {96'b0, ref_word(wrd_in)} : ref_block(blk_in);
                m_last = side;
            end
        end
        @(negedge clk);
        t++;
    endtask

    task automatic idle();
        tick(1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cycle=%0d", t);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] op;
        for (int x = 0; x < 256; x++) sb[x] = sbox_math(8'(x));
        rst = 1'b0;
        blk_req = 1'b0;
        wrd_req = 1'b0;
        blk_in = '0;
        wrd_in = '0;
        act = 1'b0;
        side = 1'b0;
        m_last = 1'b1;
        st = 0;
        len = 0;
        m_res = '0;
        m_blk_out = '0;
        m_wrd_out = '0;
        repeat (3) @(negedge clk);

        tick(1'b1, '0, 1'b0, '0, 1'b0);
        repeat (20) idle();
        check("blk_zero", blk_out, {16{8'h63}});

        tick(1'b0, '0, 1'b1, 32'h0000_0053, 1'b0);
        repeat (7) idle();
        check("wrd_53", 128'(wrd_out), 128'h636363ed);

        tick(1'b0, '0, 1'b0, '0, 1'b1);
        tick(1'b1, {16{8'hff}}, 1'b1, 32'h0000_0001, 1'b0);
        check("tie_first", 128'(gnt), 128'(2'b01));
        repeat (25) idle();
        check("tie_blk", blk_out, {16{8'h16}});
        check("tie_wrd", 128'(wrd_out), 128'h6363637c);

        tick(1'b1, rnd128(), 1'b1, $urandom, 1'b0);
        check("tie_again", 128'(gnt), 128'(2'b01));
        repeat (25) idle();

        repeat (20) tick(1'b0, '0, 1'b1, $urandom, 1'b0);
        repeat (6) idle();

        tick(1'b1, rnd128(), 1'b0, '0, 1'b0);
        repeat (7) idle();
        tick(1'b0, '0, 1'b0, '0, 1'b1);
        check("rst_gnt", 128'(gnt), 128'(2'b00));
        check("rst_blk_out", blk_out, '0);
        tick(1'b0, '0, 1'b1, $urandom, 1'b0);
        repeat (7) idle();

        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < 16; i++) op[8*i +: 8] = 8'(k * 16 + i);
            tick(1'b1, op, 1'b0, '0, 1'b0);
            repeat (18) idle();
            if (k == 0) check("sbox_00", 128'(blk_out[7:0]), 128'(8'h63));
            if (k == 5) check("sbox_53", 128'(blk_out[31:24]), 128'(8'hed));
            if (k == 15) check("sbox_ff", 128'(blk_out[127:120]), 128'(8'h16));
        end

        repeat (3000) begin
            tick($urandom_range(0, 2) == 0, rnd128(),
                 $urandom_range(0, 2) == 0, $urandom,
                 $urandom_range(0, 599) == 0);
        end
        repeat (20) idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
